// File: rtl/password_checker.sv
// -----------------------------------------------------------------------------
// password_checker
//   Holds a 4-digit password store, written by the password-setter stage, and
//   checks digits entered one per enable strobe against it. After the fourth
//   digit it either opens (unlocked held for OPEN_CYCLES cycles) or records a
//   failed attempt. Reaching MAX_FAILS consecutive failures latches the alarm.
//
// Optional feature (macro PASSWORD_CHECKER_ADMIN_EN):
//   Adds parameter ADMIN_CODE. While in alarm, enable strobes collect a 4-digit
//   shadow code, most significant digit first. A matching code clears the alarm
//   and the failure count. Without the macro, only RST leaves the alarm state.
//
// Ports:
//   CLK        in   1       clock, all state on rising edge
//   RST        in   1       asynchronous active-high reset
//   wrData     in   4       digit to store (from setter)
//   wrAddress  in   2       store index 0..3 (from setter)
//   wrEnable   in   1       store write strobe (from setter)
//   enable     in   1       one-cycle digit-entry strobe
//   digit      in   4       entered digit, sampled when enable=1
//   unlocked   out  1       high during the open window
//   alarm      out  1       latched alarm
//   failCount  out  FAIL_W  consecutive failed attempts
//   dbgState   out  3       current state encoding
// -----------------------------------------------------------------------------
module password_checker #(
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned OPEN_CYCLES = 8,
    parameter int unsigned FAIL_W      = 4
`ifdef PASSWORD_CHECKER_ADMIN_EN
    ,
    parameter logic [15:0] ADMIN_CODE  = 16'h9999
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        wrData,
    input  logic [1:0]        wrAddress,
    input  logic              wrEnable,
    input  logic              enable,
    input  logic [3:0]        digit,
    output logic              unlocked,
    output logic              alarm,
    output logic [FAIL_W-1:0] failCount,
    output logic [2:0]        dbgState
);

    localparam int unsigned TIMER_W = $clog2(OPEN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_D1    = 3'd1,
        S_D2    = 3'd2,
        S_D3    = 3'd3,
        S_OPEN  = 3'd4,
        S_ALARM = 3'd5
    } state_t;

    state_t               state, state_next;
    logic [3:0]           store [4];
    logic                 mismatch, mismatch_next;
    logic [FAIL_W-1:0]    fail_next;
    logic [FAIL_W-1:0]    fail_inc;
    logic [TIMER_W-1:0]   open_timer, timer_next;
    logic [1:0]           index;
    logic                 final_mismatch;
    logic                 unlocked_next;
    logic                 alarm_next;

`ifdef PASSWORD_CHECKER_ADMIN_EN
    logic [11:0]          shadow, shadow_next;
    logic [1:0]           shadow_cnt, shadow_cnt_next;
`endif

    // Store position compared against in each entry state.
    always_comb begin
        index = 2'd0;
        case (state)
            S_D1:    index = 2'd1;
            S_D2:    index = 2'd2;
            S_D3:    index = 2'd3;
            default: index = 2'd0;
        endcase
    end

    assign fail_inc       = failCount + FAIL_W'(1);
    assign final_mismatch = mismatch | (digit != store[3]);

    // Password store: setter writes are accepted in every state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                store[i] <= 4'd0;
            end
        end else if (wrEnable) begin
            store[wrAddress] <= wrData;
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            mismatch   <= 1'b0;
            failCount  <= '0;
            open_timer <= '0;
            unlocked   <= 1'b0;
            alarm      <= 1'b0;
            dbgState   <= 3'd0;
`ifdef PASSWORD_CHECKER_ADMIN_EN
            shadow     <= '0;
            shadow_cnt <= '0;
`endif
        end else begin
            state      <= state_next;
            mismatch   <= mismatch_next;
            failCount  <= fail_next;
            open_timer <= timer_next;
            unlocked   <= unlocked_next;
            alarm      <= alarm_next;
            dbgState   <= 3'(state_next);
`ifdef PASSWORD_CHECKER_ADMIN_EN
            shadow     <= shadow_next;
            shadow_cnt <= shadow_cnt_next;
`endif
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next    = state;
        mismatch_next = mismatch;
        fail_next     = failCount;
        timer_next    = open_timer;
`ifdef PASSWORD_CHECKER_ADMIN_EN
        shadow_next     = shadow;
        shadow_cnt_next = shadow_cnt;
`endif

        case (state)
            S_IDLE, S_D1, S_D2: begin
                // A store write aborts entry and swallows a coincident digit.
                if (wrEnable) begin
                    state_next    = S_IDLE;
                    mismatch_next = 1'b0;
                end else if (enable) begin
                    mismatch_next = mismatch | (digit != store[index]);
                    case (state)
                        S_IDLE:  state_next = S_D1;
                        S_D1:    state_next = S_D2;
                        default: state_next = S_D3;
                    endcase
                end
            end

            S_D3: begin
                if (wrEnable) begin
                    state_next    = S_IDLE;
                    mismatch_next = 1'b0;
                end else if (enable) begin
                    mismatch_next = 1'b0;
                    if (!final_mismatch) begin
                        state_next = S_OPEN;
                        timer_next = TIMER_W'(OPEN_CYCLES);
                        fail_next  = '0;
                    end else begin
                        // failCount is always below MAX_FAILS here, so the
                        // increment stops exactly at the limit.
                        fail_next = fail_inc;
                        if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                            state_next = S_ALARM;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                end
            end

            S_OPEN: begin
                // Timer counts OPEN_CYCLES..1; leaving on 1 gives exact width.
                if (open_timer <= TIMER_W'(1)) begin
                    state_next = S_IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = open_timer - TIMER_W'(1);
                end
            end

            S_ALARM: begin
`ifdef PASSWORD_CHECKER_ADMIN_EN
                // Shadow code entry; a write restarts the sequence.
                if (wrEnable) begin
                    shadow_cnt_next = 2'd0;
                end else if (enable) begin
                    if (shadow_cnt == 2'd3) begin
                        shadow_cnt_next = 2'd0;
                        if ({shadow, digit} == ADMIN_CODE) begin
                            state_next = S_IDLE;
                            fail_next  = '0;
                        end
                    end else begin
                        shadow_next     = {shadow[7:0], digit};
                        shadow_cnt_next = shadow_cnt + 2'd1;
                    end
                end
`endif
            end

            default: begin
                state_next    = S_IDLE;
                mismatch_next = 1'b0;
            end
        endcase

        // Registered outputs follow the state being entered.
        unlocked_next = (state_next == S_OPEN);
        alarm_next    = (state_next == S_ALARM);
    end

endmodule

// File: tb/tb_password_checker.sv
// -----------------------------------------------------------------------------
// tb_password_checker
//   Directed bench for password_checker. Inputs change 1 ns after a rising
//   edge; outputs are sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_password_checker;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] wrData = 4'd0;
    logic [1:0] wrAddress = 2'd0;
    logic       wrEnable = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       unlocked;
    logic       alarm;
    logic [3:0] failCount;
    logic [2:0] dbgState;

    int total = 0;
    int bad   = 0;

    password_checker dut (
        .CLK       (CLK),
        .RST       (RST),
        .wrData    (wrData),
        .wrAddress (wrAddress),
        .wrEnable  (wrEnable),
        .enable    (enable),
        .digit     (digit),
        .unlocked  (unlocked),
        .alarm     (alarm),
        .failCount (failCount),
        .dbgState  (dbgState)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write(input logic [1:0] a, input logic [3:0] d);
        wrEnable  = 1'b1;
        wrAddress = a;
        wrData    = d;
        tick();
        wrEnable  = 1'b0;
    endtask

    task automatic enter(input logic [3:0] d);
        enable = 1'b1;
        digit  = d;
        tick();
        enable = 1'b0;
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        enter(a);
        enter(b);
        enter(c);
        enter(d);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".unlocked"}, 8'(unlocked), 8'd0);
        check({tag, ".alarm"},    8'(alarm),    8'd0);
        check({tag, ".fail"},     8'(failCount), 8'd0);
        check({tag, ".state"},    8'(dbgState), 8'd0);
    endtask

    // Checks the full open window following a deciding edge.
    task automatic check_open_window(input string tag);
        for (int i = 0; i < 8; i++) begin
            check({tag, ".open"}, 8'(unlocked), 8'd1);
            tick();
        end
        check({tag, ".closed"}, 8'(unlocked), 8'd0);
        check({tag, ".state"},  8'(dbgState), 8'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_idle_outputs("reset");
        RST = 1'b0;
        tick();

        // Correct entry opens for exactly 8 cycles
        write(2'd0, 4'd1);
        write(2'd1, 4'd2);
        write(2'd2, 4'd3);
        write(2'd3, 4'd4);
        check("idle_after_writes", 8'(dbgState), 8'd0);
        enter(4'd1);
        check("state_d1", 8'(dbgState), 8'd1);
        enter(4'd2);
        check("state_d2", 8'(dbgState), 8'd2);
        enter(4'd3);
        check("state_d3", 8'(dbgState), 8'd3);
        check("no_early_open", 8'(unlocked), 8'd0);
        enter(4'd4);
        check("state_open", 8'(dbgState), 8'd4);
        check("fail_after_open", 8'(failCount), 8'd0);
        check_open_window("open1");

        // Three wrong attempts latch the alarm
        enter4(4'd1, 4'd2, 4'd3, 4'd5);
        check("fail1", 8'(failCount), 8'd1);
        check("fail1_state", 8'(dbgState), 8'd0);
        check("fail1_alarm", 8'(alarm), 8'd0);
        enter4(4'd1, 4'd2, 4'd3, 4'd5);
        check("fail2", 8'(failCount), 8'd2);
        check("fail2_alarm", 8'(alarm), 8'd0);
        enter4(4'd1, 4'd2, 4'd3, 4'd5);
        check("fail3", 8'(failCount), 8'd3);
        check("alarm_set", 8'(alarm), 8'd1);
        check("alarm_state", 8'(dbgState), 8'd5);
        enter4(4'd1, 4'd2, 4'd3, 4'd4);
        check("alarm_ignores_entry_unl", 8'(unlocked), 8'd0);
        check("alarm_ignores_entry_alm", 8'(alarm), 8'd1);
        check("alarm_fail_hold", 8'(failCount), 8'd3);
        tick();
        check("alarm_no_late_open", 8'(unlocked), 8'd0);

`ifdef PASSWORD_CHECKER_ADMIN_EN
        // Wrong admin code keeps alarm, right one clears it
        enter4(4'd9, 4'd9, 4'd9, 4'd8);
        check("admin_wrong_alarm", 8'(alarm), 8'd1);
        check("admin_wrong_state", 8'(dbgState), 8'd5);
        enter4(4'd9, 4'd9, 4'd9, 4'd9);
        check_idle_outputs("admin_ok");
        // Re-enter alarm for the reset-in-alarm case below
        enter4(4'd0, 4'd0, 4'd0, 4'd0);
        enter4(4'd0, 4'd0, 4'd0, 4'd0);
        enter4(4'd0, 4'd0, 4'd0, 4'd0);
        check("realarm", 8'(alarm), 8'd1);
`endif

        // Asynchronous reset during alarm
        RST = 1'b1;
        #2;
        check_idle_outputs("rst_alarm");
        tick();
        RST = 1'b0;
        tick();

        // Store cleared by reset: 0000 opens; reset mid-open
        enter4(4'd0, 4'd0, 4'd0, 4'd0);
        check("zero_code_open", 8'(unlocked), 8'd1);
        tick();
        tick();
        check("open_mid", 8'(unlocked), 8'd1);
        RST = 1'b1;
        #2;
        check_idle_outputs("rst_open");
        tick();
        RST = 1'b0;
        tick();
        enter4(4'd0, 4'd0, 4'd0, 4'd0);
        check_open_window("open_zero");

        // Write aborts entry; mismatch cleared, failCount kept
        write(2'd0, 4'd1);
        write(2'd1, 4'd2);
        write(2'd2, 4'd3);
        write(2'd3, 4'd4);
        enter4(4'd1, 4'd2, 4'd3, 4'd5);
        check("abort_pre_fail", 8'(failCount), 8'd1);
        enter(4'd9);
        enter(4'd2);
        check("abort_pre_state", 8'(dbgState), 8'd2);
        write(2'd0, 4'd7);
        check("abort_state", 8'(dbgState), 8'd0);
        check("abort_fail_kept", 8'(failCount), 8'd1);
        enter4(4'd7, 4'd2, 4'd3, 4'd4);
        check("abort_then_open", 8'(unlocked), 8'd1);
        check("abort_open_fail_clr", 8'(failCount), 8'd0);
        check_open_window("open_abort");

        // Simultaneous write and enable: write wins, digit discarded
        enable    = 1'b1;
        digit     = 4'd1;
        wrEnable  = 1'b1;
        wrAddress = 2'd3;
        wrData    = 4'd9;
        tick();
        enable    = 1'b0;
        wrEnable  = 1'b0;
        check("simul_state", 8'(dbgState), 8'd0);
        enter4(4'd7, 4'd2, 4'd3, 4'd9);
        check("simul_open", 8'(unlocked), 8'd1);
        check("simul_fail", 8'(failCount), 8'd0);
        check_open_window("open_simul");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/password_checker.md
Name: password_checker

Overview:
- Downstream consumer of the password-setting stage: holds the 4-digit password store and verifies serially entered digits against it.
- Store is written through the setter's data/address/write-strobe output; the entry path takes one digit per enable pulse.
- After four digits the block declares unlock or failure, counts consecutive failures, and latches an alarm at the limit.
- Output drives the lock's indicator and LED stage.

Parameters:
- MAX_FAILS, 3: consecutive failed attempts that trigger alarm (1..15).
- OPEN_CYCLES, 8: clock cycles unlocked is held high (>=1).
- FAIL_W, 4: width of failCount; must hold MAX_FAILS.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- wrData  in  4  digit to store, from setter.
- wrAddress  in  2  store index 0..3, from setter.
- wrEnable  in  1  store write strobe, from setter.
- enable  in  1  one-cycle digit-entry strobe.
- digit  in  4  entered digit, sampled when enable=1.
- unlocked  out  1  high during the open window.
- alarm  out  1  latched alarm.
- failCount  out  FAIL_W  consecutive failed attempts.
- dbgState  out  3  current state encoding, for debug.

Behaviour:
- Reset (async, RST=1):
  - store[0..3]=0, state=S_IDLE, index=0, mismatch=0, failCount=0, openTimer=0.
  - unlocked=0, alarm=0, dbgState=0.
  - Reset mid-entry or mid-open aborts immediately.
- States, with dbgState encoding: S_IDLE=0, S_D1=1, S_D2=2, S_D3=3, S_OPEN=4, S_ALARM=5.
- Store write: wrEnable=1 writes wrData into store[wrAddress] at the clock edge. Writes are accepted in every state, including S_ALARM.
- Write aborts entry: wrEnable=1 while in S_D1..S_D3 returns to S_IDLE and clears mismatch. failCount is unchanged.
- Simultaneous wrEnable and enable: the write wins and the digit is discarded.
- Entry:
  - In S_IDLE/S_D1/S_D2, enable=1 compares digit against store[index], where index = 0/1/2 respectively.
  - mismatch |= (digit != store[index]), then advance to the next state.
- Decision in S_D3, on enable=1:
  - Final mismatch = mismatch | (digit != store[3]).
  - If 0: go to S_OPEN, openTimer=OPEN_CYCLES, failCount=0.
  - If 1: failCount+1. If the new value == MAX_FAILS, go to S_ALARM; else go to S_IDLE.
  - mismatch is cleared either way.
- Comparisons use the store value at the comparing edge. A write in the same cycle is excluded by the abort rule.
- S_OPEN:
  - unlocked=1 (registered, first high the cycle after the deciding edge).
  - openTimer decrements each cycle; on reaching 1 the next state is S_IDLE. Total unlocked width = OPEN_CYCLES cycles.
  - enable is ignored in S_OPEN.
- S_ALARM:
  - alarm=1, enable ignored, stays until RST.
  - failCount holds at MAX_FAILS.
- Outputs are registered. unlocked and alarm are never both 1.
- No wrap-around: failCount saturates at MAX_FAILS.

Optional Feature:
- Macro: PASSWORD_CHECKER_ADMIN_EN.
- When defined:
  - Parameter ADMIN_CODE (16 bits, default 16'h9999) is added.
  - In S_ALARM, enable strobes feed a 4-digit shadow entry sequence, most significant digit first.
  - After the 4th digit, if the 16-bit value == ADMIN_CODE: alarm and failCount clear, state goes to S_IDLE. Otherwise the shadow sequence restarts and alarm stays.
  - A wrEnable during shadow entry restarts the shadow sequence.
- When undefined: S_ALARM exits only by RST, and the ADMIN_CODE parameter does not exist.

Test Plan:
- Write store via setter strobes 1,2,3,4 to addresses 0..3; enter 1,2,3,4 -> unlocked high exactly 8 cycles starting the cycle after the 4th digit; failCount=0; returns to S_IDLE.
- Store 1,2,3,4; enter 1,2,3,5 three times -> failCount 1,2, then alarm=1, failCount=3; a following entry of 1,2,3,4 is ignored and unlocked stays 0.
- Enter 1,2 then assert wrEnable (addr 0, data 7) -> state S_IDLE, failCount unchanged, store[0]=7; entering 7,2,3,4 -> unlocked.
- Enable and wrEnable in the same cycle (digit 1, write addr 3 data 9) -> digit discarded, store[3]=9, state stays S_IDLE.
- Assert RST during S_OPEN (and separately during S_ALARM) -> unlocked=0, alarm=0, failCount=0, store reads 0 asynchronously; entering 0,0,0,0 -> unlocked.
- With PASSWORD_CHECKER_ADMIN_EN: in alarm, enter 9,9,9,9 -> alarm=0, failCount=0, state S_IDLE. Entering 9,9,9,8 instead -> alarm stays 1.
